// File: rtl/fifo_axis_reader.sv
// Read-domain drain engine: pops a show-ahead FIFO into an AXI4-Stream master with
// fixed-length tlast framing, a 2-entry skid buffer, run/stop control and counters.
module fifo_axis_reader #(
   parameter int unsigned WIDTH         = 512,
   parameter int unsigned BEATS_PER_PKT = 16,
   parameter int unsigned CNT_WIDTH     = 32
) (
   input  logic                 rd_clk,
   input  logic                 rd_rst_n,
   input  logic                 enable,
   input  logic [WIDTH-1:0]     fifo_data,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   output logic [WIDTH-1:0]     m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] beat_count,
   output logic [CNT_WIDTH-1:0] pkt_count
);

   localparam int unsigned IDX_W = (BEATS_PER_PKT > 1) ? $clog2(BEATS_PER_PKT) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BEATS_PER_PKT - 1);

   typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic             vld1, vld0_nxt, vld1_nxt;
   logic [WIDTH-1:0] tail_data;
   logic             tail_last;
   logic             pop_allowed, push, push_last, hs;

   assign hs          = m_axis_tvalid & m_axis_tready;
   assign pop_allowed = (state != IDLE);
   assign fifo_rd_en  = pop_allowed & ~fifo_empty & (~vld1 | hs);
   assign push        = fifo_rd_en;
   assign push_last   = (idx == IDX_LAST);

   // Next state and beat index; idx_nxt lets a tlast pop count as a packet boundary
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      if (push) idx_nxt = push_last ? '0 : idx + IDX_W'(1);
      unique case (state)
         IDLE: if (enable) state_nxt = RUN;
         RUN:  if (!enable) state_nxt = (idx_nxt == '0) ? IDLE : STOP;
         STOP: begin
            if (enable)                  state_nxt = RUN;
            else if (push && push_last)  state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Buffer occupancy next values; head is entry 0 and drives the stream
   always_comb begin
      vld0_nxt = m_axis_tvalid;
      vld1_nxt = vld1;
      unique case ({push, hs})
         2'b01: begin
            vld0_nxt = vld1;
            vld1_nxt = 1'b0;
         end
         2'b10: begin
            if (m_axis_tvalid) vld1_nxt = 1'b1;
            else               vld0_nxt = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         m_axis_tvalid <= 1'b0;
         vld1          <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         tail_data     <= '0;
         tail_last     <= 1'b0;
         busy          <= 1'b0;
         beat_count    <= '0;
         pkt_count     <= '0;
      end else begin
         state         <= state_nxt;
         idx           <= idx_nxt;
         m_axis_tvalid <= vld0_nxt;
         vld1          <= vld1_nxt;
         busy          <= (state_nxt != IDLE) | vld0_nxt;

         if (push && (!m_axis_tvalid || (hs && !vld1))) begin
            m_axis_tdata <= fifo_data;
            m_axis_tlast <= push_last;
         end else if (hs && vld1) begin
            m_axis_tdata <= tail_data;
            m_axis_tlast <= tail_last;
         end

         if (push && m_axis_tvalid && (vld1 || !hs)) begin
            tail_data <= fifo_data;
            tail_last <= push_last;
         end

         if (hs) begin
            beat_count <= beat_count + CNT_WIDTH'(1);
            if (m_axis_tlast) pkt_count <= pkt_count + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Directed self-checking bench for fifo_axis_reader with a show-ahead FIFO model and
// a scoreboard of expected beats filled as words are written into the model.
module tb_fifo_axis_reader;

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 32;
   localparam int unsigned BPP = 16;

   typedef struct packed {
      logic [W-1:0] d;
      logic         l;
   } exp_t;

   logic          rd_clk = 1'b0;
   logic          rd_rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          tready = 1'b0;
   logic [W-1:0]  fifo_data;
   logic          fifo_empty, fifo_rd_en;
   logic [W-1:0]  tdata;
   logic          tvalid, tlast, busy;
   logic [CW-1:0] beat_count, pkt_count;

   logic          enable1 = 1'b0;
   logic [W-1:0]  fifo_data1;
   logic          fifo_empty1, fifo_rd_en1;
   logic [W-1:0]  tdata1;
   logic          tvalid1, tlast1, busy1;
   logic [CW-1:0] beat_count1, pkt_count1;

   int            vectors = 0;
   int            errors  = 0;

   logic [W-1:0]  mem [64];
   logic [6:0]    wr_ptr = '0;
   logic [6:0]    rd_ptr;
   int            pop_cnt;
   int            wr_ord = 0;
   exp_t          sb [$];

   logic [W-1:0]  mem1 [8];
   logic [3:0]    wr_ptr1 = '0;
   logic [3:0]    rd_ptr1;

   always #5 rd_clk = ~rd_clk;

   fifo_axis_reader #(.WIDTH(W), .BEATS_PER_PKT(BPP), .CNT_WIDTH(CW)) u_dut (
      .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .enable(enable),
      .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .m_axis_tlast(tlast), .busy(busy), .beat_count(beat_count), .pkt_count(pkt_count)
   );

   fifo_axis_reader #(.WIDTH(W), .BEATS_PER_PKT(1), .CNT_WIDTH(CW)) u_dut1 (
      .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .enable(enable1),
      .fifo_data(fifo_data1), .fifo_empty(fifo_empty1), .fifo_rd_en(fifo_rd_en1),
      .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(1'b1),
      .m_axis_tlast(tlast1), .busy(busy1), .beat_count(beat_count1), .pkt_count(pkt_count1)
   );

   // Show-ahead FIFO models; read pointers reset with the read domain
   assign fifo_data   = mem[rd_ptr[5:0]];
   assign fifo_empty  = (rd_ptr == wr_ptr);
   assign fifo_data1  = mem1[rd_ptr1[2:0]];
   assign fifo_empty1 = (rd_ptr1 == wr_ptr1);

   always @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         rd_ptr  <= '0;
         pop_cnt <= 0;
         rd_ptr1 <= '0;
      end else begin
         if (fifo_rd_en) begin
            rd_ptr  <= rd_ptr + 7'd1;
            pop_cnt <= pop_cnt + 1;
         end
         if (fifo_rd_en1) rd_ptr1 <= rd_ptr1 + 4'd1;
      end
   end

   // Stream monitor: scoreboard compare on handshake, stall stability, buffer depth bound
   int           acc_cnt = 0;
   logic         stall_pend = 1'b0;
   logic [W-1:0] stall_d;
   logic         stall_l;
   exp_t         e;

   always @(negedge rd_clk) begin
      if (!rd_rst_n) begin
         acc_cnt    = 0;
         stall_pend = 1'b0;
      end else begin
         if (stall_pend) begin
            vectors++;
            assert (tvalid === 1'b1 && tdata === stall_d && tlast === stall_l) else begin
               errors++;
               $error("FAIL stall_hold got v=%0b d=%0h l=%0b exp v=1 d=%0h l=%0b",
                      tvalid, tdata, tlast, stall_d, stall_l);
            end
         end
         stall_pend = tvalid && !tready;
         stall_d    = tdata;
         stall_l    = tlast;
         if (tvalid) begin
            vectors++;
            assert ((pop_cnt - acc_cnt) <= 2) else begin
               errors++;
               $error("FAIL pop_ahead got %0d exp <=2", pop_cnt - acc_cnt);
            end
         end
         if (tvalid && tready) begin
            acc_cnt++;
            vectors++;
            if (sb.size() == 0) begin
               errors++;
               $error("FAIL beat_extra got d=%0h exp no beat", tdata);
            end else begin
               e = sb.pop_front();
               assert (tdata === e.d && tlast === e.l) else begin
                  errors++;
                  $error("FAIL beat got d=%0h l=%0b exp d=%0h l=%0b", tdata, tlast, e.d, e.l);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge rd_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic write_word(input logic [W-1:0] d);
      mem[wr_ptr[5:0]] = d;
      wr_ptr = wr_ptr + 7'd1;
      sb.push_back('{d: d, l: (wr_ord == BPP - 1)});
      wr_ord = (wr_ord == BPP - 1) ? 0 : wr_ord + 1;
   endtask

   task automatic model_reset();
      wr_ptr  = '0;
      wr_ptr1 = '0;
      wr_ord  = 0;
      sb.delete();
   endtask

   task automatic do_reset();
      enable   = 1'b0;
      tready   = 1'b0;
      rd_rst_n = 1'b0;
      model_reset();
      tick();
      tick();
      rd_rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_sb(input string tag, input int budget, input logic toggle);
      for (int i = 0; i < budget && sb.size() != 0; i++) begin
         if (toggle) tready = ~tready;
         tick();
      end
      tready = 1'b1;
      tick();
      chk(tag, 64'(sb.size()), 64'd0);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget && busy !== 1'b0; i++) tick();
      chk(tag, 64'(busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      do_reset();
      rd_rst_n = 1'b0;
      #1;
      chk("rst_tvalid", 64'(tvalid), 64'd0);
      chk("rst_tlast",  64'(tlast),  64'd0);
      chk("rst_tdata",  64'(tdata),  64'd0);
      chk("rst_rd_en",  64'(fifo_rd_en), 64'd0);
      chk("rst_busy",   64'(busy),   64'd0);
      chk("rst_beats",  64'(beat_count), 64'd0);
      chk("rst_pkts",   64'(pkt_count),  64'd0);
      tick();
      rd_rst_n = 1'b1;
      tick();

      // 1: full-rate stream of 0..31
      for (int i = 0; i < 32; i++) write_word(W'(i));
      tready = 1'b1;
      tick();
      enable = 1'b1;
      #1;
      chk("t1_rd_en_idle", 64'(fifo_rd_en), 64'd0);
      tick();
      chk("t1_rd_en_first", 64'(fifo_rd_en), 64'd1);
      chk("t1_tvalid_lat", 64'(tvalid), 64'd0);
      tick();
      for (int i = 0; i < 32; i++) begin
         chk("t1_stream", 64'(tvalid), 64'd1);
         tick();
      end
      chk("t1_drained", 64'(sb.size()), 64'd0);
      chk("t1_beats", 64'(beat_count), 64'd32);
      chk("t1_pkts",  64'(pkt_count),  64'd2);
      enable = 1'b0;
      wait_idle("t1_idle", 20);

      // 2: toggling backpressure
      do_reset();
      for (int i = 0; i < 32; i++) write_word(W'(32'h2000 + i));
      enable = 1'b1;
      wait_sb("t2_drain", 200, 1'b1);
      chk("t2_beats", 64'(beat_count), 64'd32);
      chk("t2_pkts",  64'(pkt_count),  64'd2);
      enable = 1'b0;
      wait_idle("t2_idle", 20);

      // 3: stop request mid-packet finishes the packet
      do_reset();
      for (int i = 0; i < 32; i++) write_word(W'(32'h3000 + i));
      tready = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 50 && pop_cnt < 6; i++) tick();
      chk("t3_pop6", 64'(pop_cnt), 64'd6);
      enable = 1'b0;
      wait_idle("t3_idle", 60);
      chk("t3_beats", 64'(beat_count), 64'd16);
      chk("t3_pkts",  64'(pkt_count),  64'd1);
      repeat (5) tick();
      chk("t3_rd_en", 64'(fifo_rd_en), 64'd0);
      chk("t3_pops",  64'(pop_cnt), 64'd16);
      chk("t3_left",  64'(sb.size()), 64'd16);

      // 4: FIFO runs dry mid-packet
      do_reset();
      for (int i = 0; i < 7; i++) write_word(W'(32'h4000 + i));
      tready = 1'b1;
      enable = 1'b1;
      repeat (20) tick();
      chk("t4_gap_tvalid", 64'(tvalid), 64'd0);
      chk("t4_gap_busy",   64'(busy),   64'd1);
      chk("t4_gap_pkts",   64'(pkt_count), 64'd0);
      for (int i = 7; i < 16; i++) write_word(W'(32'h4000 + i));
      wait_sb("t4_drain", 60, 1'b0);
      chk("t4_beats", 64'(beat_count), 64'd16);
      chk("t4_pkts",  64'(pkt_count),  64'd1);
      enable = 1'b0;
      wait_idle("t4_idle", 20);

      // 5: reset mid-packet discards the partial packet
      do_reset();
      for (int i = 0; i < 16; i++) write_word(W'(32'h5000 + i));
      tready = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 50 && pop_cnt < 9; i++) tick();
      rd_rst_n = 1'b0;
      model_reset();
      #1;
      chk("t5_tvalid", 64'(tvalid), 64'd0);
      chk("t5_tlast",  64'(tlast),  64'd0);
      chk("t5_busy",   64'(busy),   64'd0);
      chk("t5_beats",  64'(beat_count), 64'd0);
      chk("t5_rd_en",  64'(fifo_rd_en), 64'd0);
      tick();
      rd_rst_n = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) write_word(W'(32'h5100 + i));
      wait_sb("t5_drain", 60, 1'b0);
      chk("t5_post_beats", 64'(beat_count), 64'd16);
      chk("t5_post_pkts",  64'(pkt_count),  64'd1);
      enable = 1'b0;
      wait_idle("t5_idle", 20);

      // 6: single-beat packets
      for (int i = 0; i < 4; i++) begin
         mem1[i] = W'(32'h6000 + i);
         wr_ptr1 = wr_ptr1 + 4'd1;
      end
      enable1 = 1'b1;
      k = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (tvalid1 === 1'b1) begin
            chk("t6_tlast", 64'(tlast1), 64'd1);
            chk("t6_tdata", 64'(tdata1), 64'(32'h6000 + k));
            k++;
         end
      end
      chk("t6_nbeats", 64'(k), 64'd4);
      chk("t6_pkts",   64'(pkt_count1), 64'd4);
      chk("t6_beats",  64'(beat_count1), 64'd4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
